// File: rtl/vga_pkg.sv
// Shared raster timing defaults and helpers for the VGA timing generator.
// Default set is 1024x768 @ 60 Hz with a 65 MHz pixel clock.
package vga_pkg;

    localparam int CNT_W   = 11;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    localparam int H_ACTIVE_DEF = 1024;
    localparam int H_FP_DEF     = 24;
    localparam int H_SYNC_DEF   = 136;
    localparam int H_BP_DEF     = 160;

    localparam int V_ACTIVE_DEF = 768;
    localparam int V_FP_DEF     = 3;
    localparam int V_SYNC_DEF   = 6;
    localparam int V_BP_DEF     = 29;

    function automatic int axis_total(input int active, input int fp,
                                      input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter with registered sync/blank flags that
// always describe the same position as the counter.
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int ACTIVE = H_ACTIVE_DEF,
    parameter int FP     = H_FP_DEF,
    parameter int SYNC   = H_SYNC_DEF,
    parameter int BP     = H_BP_DEF,
    parameter bit POL    = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             step,
    output logic [CNT_W-1:0] count,
    output logic             sync,
    output logic             blnk,
    output logic             wrap
);

    localparam int TOTAL = axis_total(ACTIVE, FP, SYNC, BP);

    if (TOTAL > CNT_MAX) begin : g_total_too_large
        $error("vga_axis_counter: axis total %0d exceeds %0d", TOTAL, CNT_MAX);
    end

    localparam logic [CNT_W-1:0] LAST_C    = CNT_W'(TOTAL - 1);
    localparam logic [CNT_W-1:0] ACTIVE_C  = CNT_W'(ACTIVE);
    localparam logic [CNT_W-1:0] SYNC_LO_C = CNT_W'(ACTIVE + FP);
    localparam logic [CNT_W-1:0] SYNC_HI_C = CNT_W'(ACTIVE + FP + SYNC);

    logic [CNT_W-1:0] count_q, count_d;
    logic             sync_q, blnk_q;

    function automatic logic in_sync(input logic [CNT_W-1:0] c);
        return (c >= SYNC_LO_C) && (c < SYNC_HI_C);
    endfunction

    always_comb begin
        count_d = count_q;
        if (step) begin
            count_d = (count_q == LAST_C) ? '0 : count_q + 1'b1;
        end
    end

    // Flags are computed from count_d so they land on the same edge as the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            sync_q  <= ~POL;
            blnk_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            sync_q  <= in_sync(count_d) ? POL : ~POL;
            blnk_q  <= (count_d >= ACTIVE_C);
        end
    end

    assign count = count_q;
    assign sync  = sync_q;
    assign blnk  = blnk_q;
    assign wrap  = (count_q == LAST_C);

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing for the Pong display chain: pixel/line counters, sync,
// blanking, plus a frame-start strobe and frame counter for game pacing.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE  = H_ACTIVE_DEF,
    parameter int H_FP      = H_FP_DEF,
    parameter int H_SYNC    = H_SYNC_DEF,
    parameter int H_BP      = H_BP_DEF,
    parameter int V_ACTIVE  = V_ACTIVE_DEF,
    parameter int V_FP      = V_FP_DEF,
    parameter int V_SYNC    = V_SYNC_DEF,
    parameter int V_BP      = V_BP_DEF,
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ce,
    output logic [CNT_W-1:0] hcount,
    output logic [CNT_W-1:0] vcount,
    output logic             hsync,
    output logic             vsync,
    output logic             hblnk,
    output logic             vblnk,
    output logic             frame_start,
    output logic [15:0]      frame_cnt
);

    logic h_wrap, v_wrap, v_step, frame_wrap;
    logic        frame_start_q;
    logic [15:0] frame_cnt_q;

    assign v_step     = ce & h_wrap;
    assign frame_wrap = v_step & v_wrap;

    vga_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP),
        .POL    (HSYNC_POL)
    ) u_h (
        .clk   (clk),
        .rst_n (rst_n),
        .step  (ce),
        .count (hcount),
        .sync  (hsync),
        .blnk  (hblnk),
        .wrap  (h_wrap)
    );

    vga_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP),
        .POL    (VSYNC_POL)
    ) u_v (
        .clk   (clk),
        .rst_n (rst_n),
        .step  (v_step),
        .count (vcount),
        .sync  (vsync),
        .blnk  (vblnk),
        .wrap  (v_wrap)
    );

    // Strobe is rewritten every clock so it drops even while ce holds (0,0).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_start_q <= 1'b0;
            frame_cnt_q   <= '0;
        end else begin
            frame_start_q <= frame_wrap;
            if (frame_wrap) begin
                frame_cnt_q <= frame_cnt_q + 16'd1;
            end
        end
    end

    assign frame_start = frame_start_q;
    assign frame_cnt   = frame_cnt_q;

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Generates the raster timing for the Pong display chain: the pixel counters `hcount`/`vcount`, the horizontal and vertical sync pulses, and the horizontal and vertical blanking flags. Every screen controller (menu, game, credits, and the top-level mux) consumes these signals as its `*_in` timing inputs. The block also provides a one-cycle frame-start strobe and a frame counter, which game logic uses to pace ball and paddle updates. Default timing is 1024x768 @ 60 Hz with a 65 MHz pixel clock.

## Interface
Parameters:
- `H_ACTIVE`, 1024, visible pixels per line
- `H_FP`, 24, horizontal front porch (pixels)
- `H_SYNC`, 136, horizontal sync width (pixels)
- `H_BP`, 160, horizontal back porch (pixels); line total = 1344
- `V_ACTIVE`, 768, visible lines per frame
- `V_FP`, 3, vertical front porch (lines)
- `V_SYNC`, 6, vertical sync width (lines)
- `V_BP`, 29, vertical back porch (lines); frame total = 806
- `HSYNC_POL`, 0, asserted level of `hsync`
- `VSYNC_POL`, 0, asserted level of `vsync`

Ports:
- `clk` in 1: pixel clock. One clock domain; all logic runs on its rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `ce` in 1: pixel enable. When low, all counters and flags hold their values.
- `hcount` out 11: current pixel column, 0..H_TOTAL-1
- `vcount` out 11: current line, 0..V_TOTAL-1
- `hsync` out 1: horizontal sync, at `HSYNC_POL` while asserted
- `vsync` out 1: vertical sync, at `VSYNC_POL` while asserted
- `hblnk` out 1: high while `hcount` >= H_ACTIVE
- `vblnk` out 1: high while `vcount` >= V_ACTIVE
- `frame_start` out 1: one-cycle strobe when (0,0) is presented
- `frame_cnt` out 16: number of completed frames, wraps modulo 2^16

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP. Both must be <= 2047; a value above that is an elaboration error.
- Horizontal counter: on each clock with `ce`=1, `hcount` increments. When `hcount` = H_TOTAL-1, it wraps to 0.
- Vertical counter: advances only when the horizontal counter wraps. When `vcount` = V_TOTAL-1 at the same time, it wraps to 0, which ends the frame.
- Sync windows:
  - `hsync` is asserted for H_ACTIVE+H_FP <= `hcount` < H_ACTIVE+H_FP+H_SYNC.
  - `vsync` is asserted for V_ACTIVE+V_FP <= `vcount` < V_ACTIVE+V_FP+V_SYNC.
  - Both are evaluated over the whole line. `vsync` changes only at the clock where `hcount` returns to 0.
- Blanking: `hblnk` and `vblnk` are derived from the counter values as defined in the port list. Active video is `!hblnk && !vblnk`.
- Frame strobe and count:
  - On the frame wrap (the transition into (0,0)), `frame_cnt` increments.
  - `frame_start` is set for exactly one clock. It clears on the next clock even if `ce`=0 holds the position at (0,0).
- Wrap-around: `frame_cnt` wraps from 0xFFFF to 0x0000. `frame_start` still pulses on that frame.

## Timing
- All outputs are registered. Counters, sync, and blanking flags always describe the same pixel and are never skewed against each other.
- The counter-to-flag relationship has zero cycles of latency, so the flags are computed from the next-state counter values.
- Reset values while `rst_n`=0:
  - `hcount`=0, `vcount`=0
  - `hsync`=!HSYNC_POL, `vsync`=!VSYNC_POL
  - `hblnk`=0, `vblnk`=0
  - `frame_start`=0, `frame_cnt`=0
- After reset releases, (0,0) is already presented. The first rising edge with `ce`=1 moves to (1,0).
- The first `frame_start` occurs on the first frame wrap, not at the end of reset.
- Asserting reset mid-frame clears everything immediately (asynchronous). The frame that was in progress produces no `frame_start`.
- With `ce` held at 1, the period of `frame_start` is exactly H_TOTAL*V_TOTAL clocks (1,083,264 clocks at default timing).

## Structure
- Shared package `vga_pkg` holds:
  - the default timing constants (1024x768 set);
  - the `ce`-free counter width (11);
  - the derived totals as localparam functions.
- One natural sub-module: `vga_axis_counter`.
  - It is parameterised by ACTIVE/FP/SYNC/BP and polarity.
  - It has inputs `clk`, `rst_n`, and `step`, and outputs `count`, `sync`, `blnk`, and `wrap`.
  - `vga_timing_gen` instantiates it twice: the horizontal instance has `step`=`ce`, and the vertical instance has `step`=`ce && h.wrap`.
- Top-level glue contains only the `frame_start`/`frame_cnt` registers.

## Test plan
- Reset then `ce`=1: at cycle 1023, `hblnk`=0. At cycle 1024, `hblnk`=1. `hsync`=0 exactly over `hcount` 1048..1183. At cycle 1344, `hcount`=0 and `vcount`=1.
- Full frame: `vblnk` rises when `vcount`=768. `vsync`=0 for `vcount` 771..776. `frame_start` pulses at clock 1,083,264 with `frame_cnt`=1 and (h,v)=(0,0).
- `ce` toggling 1-0-1: `hcount` advances only on `ce`=1 clocks. Holding `ce`=0 at (0,0) gives a single-cycle `frame_start`, and the frame period scales by the inverse of the `ce` duty.
- Asynchronous reset asserted at (500,300) between clock edges: all outputs take their reset values immediately. No `frame_start` appears, and counting restarts from (0,0) after release.
- Force `frame_cnt` to 0xFFFF (or run 65,536 frames with small parameters, e.g. 8/1/2/1 x 4/1/1/1): the next wrap gives `frame_cnt`=0 with `frame_start`=1.
- Polarity parameters set to 1: `hsync`/`vsync` are high inside their windows and 0 in reset; window positions are unchanged.
